// File: rtl/uart_rx_buffer.sv
// Receive-side byte FIFO between the UART receiver shift logic and the host bus.
// Define RX_FRAMING_ERR_EN to carry a per-byte framing-error flag alongside the data.
module uart_rx_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          rClk,
  input  logic          rRst,
  input  logic [7:0]    rdataIn,
`ifdef RX_FRAMING_ERR_EN
  input  logic          rferrIn,
  output logic          rferrOut,
`endif
  input  logic          rWR,
  input  logic          rRD,
  input  logic          rovfClr,
  output logic [7:0]    rdataOut,
  output logic          rvalid,
  output logic          rEMPTY,
  output logic          rFULL,
  output logic          rxrdy,
  output logic          roverflow,
  output logic [AW:0]   rcount
);

`ifdef RX_FRAMING_ERR_EN
  localparam int unsigned EW = 9;
`else
  localparam int unsigned EW = 8;
`endif

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wptr_q,   wptr_d;
  logic [AW-1:0] rptr_q,   rptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [EW-1:0] rdata_q,  rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          ovf_q,    ovf_d;

  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          ovf_set;
  logic [EW-1:0] wr_entry;

`ifdef RX_FRAMING_ERR_EN
  assign wr_entry = {rferrIn, rdataIn};
`else
  assign wr_entry = rdataIn;
`endif

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = rRD & ~empty;
  // A full FIFO still accepts a byte when a pop frees the oldest slot in the same cycle.
  assign do_push = rWR & (~full | do_pop);
  assign ovf_set = rWR & full & ~rRD;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    ovf_d    = ovf_q;

    if (do_push) begin
      wptr_d = wptr_q + AW'(1);
    end

    if (do_pop) begin
      rdata_d  = mem_q[rptr_q];
      rptr_d   = rptr_q + AW'(1);
      rvalid_d = 1'b1;
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    if (rovfClr) begin
      ovf_d = 1'b0;
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge rClk or posedge rRst) begin
    if (rRst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge rClk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wr_entry;
    end
  end

  assign rdataOut  = rdata_q[7:0];
`ifdef RX_FRAMING_ERR_EN
  assign rferrOut  = rdata_q[EW-1];
`endif
  assign rvalid    = rvalid_q;
  assign rEMPTY    = empty;
  assign rFULL     = full;
  assign rxrdy     = ~empty;
  assign roverflow = ovf_q;
  assign rcount    = count_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: directed vector table, hand sequences, and a
// randomized run against a queue-based reference model.
module tb_uart_rx_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          rClk = 1'b0;
  logic          rRst;
  logic [7:0]    rdataIn;
  logic          rWR;
  logic          rRD;
  logic          rovfClr;
  logic [7:0]    rdataOut;
  logic          rvalid;
  logic          rEMPTY;
  logic          rFULL;
  logic          rxrdy;
  logic          roverflow;
  logic [AW:0]   rcount;
  logic          rferrIn_tb;
  logic          rferrOut_tb;

  int checks = 0;
  int errors = 0;

  uart_rx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .rClk      (rClk),
    .rRst      (rRst),
    .rdataIn   (rdataIn),
`ifdef RX_FRAMING_ERR_EN
    .rferrIn   (rferrIn_tb),
    .rferrOut  (rferrOut_tb),
`endif
    .rWR       (rWR),
    .rRD       (rRD),
    .rovfClr   (rovfClr),
    .rdataOut  (rdataOut),
    .rvalid    (rvalid),
    .rEMPTY    (rEMPTY),
    .rFULL     (rFULL),
    .rxrdy     (rxrdy),
    .roverflow (roverflow),
    .rcount    (rcount)
  );

`ifndef RX_FRAMING_ERR_EN
  assign rferrOut_tb = 1'b0;
`endif

  always #5 rClk = ~rClk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [7:0] din;
    logic [7:0] edata;
    logic       evalid;
    int         ecount;
    logic       eovf;
  } vec_t;

  vec_t tv[$];

  logic [8:0] mq[$];
  logic [8:0] m_last;
  logic       m_valid;
  logic       m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge rClk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] ed, input logic ev,
                           input int ec, input logic eo);
    chk({tag, ".rdataOut"},  32'(rdataOut),  32'(ed));
    chk({tag, ".rvalid"},    32'(rvalid),    32'(ev));
    chk({tag, ".rcount"},    32'(rcount),    32'(ec));
    chk({tag, ".roverflow"}, 32'(roverflow), 32'(eo));
    chk({tag, ".rEMPTY"},    32'(rEMPTY),    32'(ec == 0));
    chk({tag, ".rFULL"},     32'(rFULL),     32'(ec == int'(DEPTH)));
    chk({tag, ".rxrdy"},     32'(rxrdy),     32'(ec != 0));
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic clr,
                              input logic [7:0] din, input logic [7:0] ed,
                              input logic ev, input int ec, input logic eo);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
    v.edata = ed; v.evalid = ev; v.ecount = ec; v.eovf = eo;
    return v;
  endfunction

  task automatic drive(input logic wr, input logic rd, input logic clr,
                       input logic [7:0] din, input logic fe);
    rWR = wr; rRD = rd; rovfClr = clr; rdataIn = din; rferrIn_tb = fe;
  endtask

  // One cycle of the reference model: pop (if anything is held) before deciding the push.
  task automatic model_step(input logic wr, input logic rd, input logic clr,
                            input logic [8:0] entry);
    bit popped = 0;
    m_valid = 1'b0;
    if (rd && mq.size() > 0) begin
      m_last  = mq.pop_front();
      m_valid = 1'b1;
      popped  = 1;
    end
    if (wr) begin
      if (mq.size() < DEPTH) mq.push_back(entry);
      else if (!popped) m_ovf = 1'b1;
    end
    if (clr && !(wr && !popped && mq.size() == DEPTH && !rd)) begin
      if (!(wr && !rd && mq.size() == DEPTH && !popped && m_ovf)) m_ovf = 1'b0;
    end
  endtask

  initial begin
    rRst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    chk_state("reset", 8'h00, 1'b0, 0, 1'b0);
    #10;
    rRst = 1'b0;
    tick();
    chk_state("idle", 8'h00, 1'b0, 0, 1'b0);

    tv.push_back(mk(1, 0, 0, 8'hA5, 8'h00, 0, 1, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 8'hA5, 1, 0, 0));
    tv.push_back(mk(0, 0, 0, 8'h00, 8'hA5, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 8'h11, 8'hA5, 0, 1, 0));
    tv.push_back(mk(1, 0, 0, 8'h22, 8'hA5, 0, 2, 0));
    tv.push_back(mk(1, 0, 0, 8'h33, 8'hA5, 0, 3, 0));
    tv.push_back(mk(1, 0, 0, 8'h44, 8'hA5, 0, 4, 0));
    tv.push_back(mk(1, 0, 0, 8'h55, 8'hA5, 0, 4, 1));
    tv.push_back(mk(0, 1, 0, 8'h00, 8'h11, 1, 3, 1));
    tv.push_back(mk(0, 1, 0, 8'h00, 8'h22, 1, 2, 1));
    tv.push_back(mk(0, 1, 0, 8'h00, 8'h33, 1, 1, 1));
    tv.push_back(mk(0, 1, 0, 8'h00, 8'h44, 1, 0, 1));
    tv.push_back(mk(0, 0, 1, 8'h00, 8'h44, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 8'h44, 0, 0, 0));
    tv.push_back(mk(1, 0, 0, 8'h01, 8'h44, 0, 1, 0));
    tv.push_back(mk(1, 0, 0, 8'h02, 8'h44, 0, 2, 0));
    tv.push_back(mk(1, 0, 0, 8'h03, 8'h44, 0, 3, 0));
    tv.push_back(mk(1, 0, 0, 8'h04, 8'h44, 0, 4, 0));
    tv.push_back(mk(1, 1, 0, 8'h66, 8'h01, 1, 4, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 8'h02, 1, 3, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 8'h03, 1, 2, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 8'h04, 1, 1, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 8'h66, 1, 0, 0));
    tv.push_back(mk(1, 1, 0, 8'h5A, 8'h66, 0, 1, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 8'h5A, 1, 0, 0));
    tv.push_back(mk(1, 0, 0, 8'hC1, 8'h5A, 0, 1, 0));
    tv.push_back(mk(1, 0, 0, 8'hC2, 8'h5A, 0, 2, 0));
    tv.push_back(mk(1, 0, 0, 8'hC3, 8'h5A, 0, 3, 0));
    tv.push_back(mk(1, 0, 0, 8'hC4, 8'h5A, 0, 4, 0));
    tv.push_back(mk(1, 0, 1, 8'hFF, 8'h5A, 0, 4, 1));
    tv.push_back(mk(0, 0, 1, 8'h00, 8'h5A, 0, 4, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 8'hC1, 1, 3, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 8'hC2, 1, 2, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 8'hC3, 1, 1, 0));
    tv.push_back(mk(0, 1, 0, 8'h00, 8'hC4, 1, 0, 0));

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].wr, tv[i].rd, tv[i].clr, tv[i].din, 1'b0);
      tick();
      chk_state($sformatf("vec%0d", i), tv[i].edata, tv[i].evalid, tv[i].ecount, tv[i].eovf);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(i), 1'b0);
      tick();
      chk(.name($sformatf("wrap%0d.count_push", i)), .act(32'(rcount)), .exp(32'd1));
      drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      tick();
      chk(.name($sformatf("wrap%0d.data", i)), .act(32'(rdataOut)), .exp(32'(i)));
      chk(.name($sformatf("wrap%0d.valid", i)), .act(32'(rvalid)), .exp(32'd1));
      chk(.name($sformatf("wrap%0d.count_pop", i)), .act(32'(rcount)), .exp(32'd0));
    end

    // Hold 3 entries with rvalid high, then reset between clock edges.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(8'h90 + i), 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_state("pre_areset", 8'h90, 1'b1, 3, 1'b0);
    #2;
    rRst = 1'b1;
    #1;
    chk_state("areset", 8'h00, 1'b0, 0, 1'b0);
    #2;
    rRst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h7E, 1'b0);
    tick();
    chk_state("post_rst_push", 8'h00, 1'b0, 1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    chk_state("post_rst_pop", 8'h7E, 1'b1, 0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    #3;
    rRst = 1'b1;
    #2;
    rRst = 1'b0;
    mq.delete();
    m_last  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic       wr;
      logic       rd;
      logic       clr;
      logic [7:0] d;
      logic       fe;
      bit         was_full;
      bit         popping;
      wr  = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 99) < 8);
      d   = 8'($urandom);
`ifdef RX_FRAMING_ERR_EN
      fe  = 1'($urandom);
`else
      fe  = 1'b0;
`endif
      drive(wr, rd, clr, d, fe);
      was_full = (mq.size() == DEPTH);
      popping  = rd && mq.size() > 0;
      model_step(wr, rd, 1'b0, {fe, d});
      if (clr && !(wr && was_full && !popping)) m_ovf = 1'b0;
      tick();
      chk_state($sformatf("rnd%0d", c), m_last[7:0], m_valid, mq.size(), m_ovf);
`ifdef RX_FRAMING_ERR_EN
      chk($sformatf("rnd%0d.rferrOut", c), 32'(rferrOut_tb), 32'(m_last[8]));
`endif
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Receive-side byte FIFO for the UART core; it is the receive-direction counterpart of the transmit buffer. The receiver shift logic pushes each completed byte. The host bus interface pops bytes and reads status flags. The block provides full/empty/ready status, a sticky overflow flag and a registered read-data path.

Parameters:
DEPTH, 4, number of byte entries; must be a power of two, minimum 2
AW, 2, pointer width; must equal log2(DEPTH)

Ports:
rClk  input  1  clock, all logic on rising edge
rRst  input  1  asynchronous reset, active-high
rdataIn  input  8  received byte from receiver shift register
rWR  input  1  push strobe; one-cycle pulse per completed byte
rRD  input  1  pop strobe from host interface; one cycle per byte
rovfClr  input  1  clears roverflow
rdataOut  output  8  registered popped byte
rvalid  output  1  one-cycle pulse: rdataOut updated this cycle
rEMPTY  output  1  FIFO holds zero entries
rFULL  output  1  FIFO holds DEPTH entries
rxrdy  output  1  byte available to host; equals !rEMPTY
roverflow  output  1  sticky: a byte was dropped because the FIFO was full
rcount  output  AW+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rRst high, asynchronous):
  - write pointer, read pointer and count go to 0
  - rdataOut=0, rvalid=0, roverflow=0, rEMPTY=1, rFULL=0, rxrdy=0
  - storage contents are not reset
- rEMPTY, rFULL and rxrdy decode combinationally from the registered count.
- Push: rWR=1 and FIFO not full -> mem[wptr]<=rdataIn, wptr wraps modulo DEPTH, count+1. Visible on flags the next cycle.
- Pop: rRD=1 and FIFO not empty:
  - rdataOut<=mem[rptr], rptr wraps modulo DEPTH, count-1
  - rvalid=1 for exactly that next cycle
  - read latency is one clock
- rRD while empty: ignored; rdataOut holds its previous value, rvalid=0, no underflow.
- rdataOut holds the last popped value until the next pop.
- Simultaneous rWR and rRD:
  - not empty and not full: both occur, count unchanged
  - empty: push only; the read is ignored (no write-through bypass); count becomes 1
  - full: both occur, the oldest byte is popped and the new byte is stored, count stays DEPTH, no overflow
- Overflow: rWR=1, FIFO full and no simultaneous pop -> byte dropped, memory and pointers unchanged, roverflow<=1.
- roverflow clears only on rovfClr=1. If set and clear occur in the same cycle, set wins.
- Pointers are AW bits and wrap naturally. Count saturates logically at 0 and DEPTH, guarded by the full/empty checks above.
- Asserting reset mid-operation discards all contents immediately. The first push after reset release lands in entry 0.

Optional Feature:
- Macro: RX_FRAMING_ERR_EN
- When defined:
  - adds input rferrIn (1 bit, framing-error flag of the byte on rdataIn) and output rferrOut (1 bit)
  - each entry stores 9 bits; rferrOut is registered alongside rdataOut with identical timing
  - rferrOut resets to 0 and holds its value when no pop occurs
  - overflow drops the flag with its byte
- When not defined: both ports are absent and storage is 8 bits per entry.

Test Plan:
- Reset then idle -> rEMPTY=1, rxrdy=0, rFULL=0, rcount=0, rdataOut=0x00, roverflow=0.
- Push 0xA5, then pop next cycle:
  - rxrdy=1 the cycle after the push
  - rdataOut=0xA5 with rvalid=1 one cycle after rRD
  - rEMPTY=1 afterwards
- Push 0x11,0x22,0x33,0x44 (DEPTH=4) -> rFULL=1, rcount=4. Push 0x55 -> roverflow=1, dropped. Pop 4 -> 0x11,0x22,0x33,0x44 in order. Pulse rovfClr -> roverflow=0.
- Wrap-around: 10 interleaved push/pop pairs of 0x00..0x09 -> popped in order, rcount never exceeds 1.
- With FIFO full, rWR (0x66) and rRD in the same cycle -> pops the oldest byte, rcount stays 4, roverflow stays 0. Simultaneous on empty -> rcount=1, rvalid=0.
- Assert rRst asynchronously with 3 entries held -> flags return to reset values without a clock edge. Next push 0x7E then pop -> 0x7E.
